pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences a PLL out of reset and holds the PLL-clocked logic in reset
// until the PLL has shown a stable lock. A failed attempt (lock timeout,
// or lock lost while stabilizing) pulses the PLL reset again. After
// MAX_RETRIES extra attempts the block parks in FAIL until rst. Losing lock
// while running restarts the sequence and clears the retry count.
//
// Parameters
//   RST_PULSE_CYCLES     refclk cycles pll_rst is held per attempt (>=1)
//   LOCK_TIMEOUT_CYCLES  max WAIT_LOCK dwell before the attempt fails (>=1)
//   LOCK_STABLE_CYCLES   consecutive locked cycles needed to enter RUN (>=1)
//   MAX_RETRIES          extra attempts after the first (0..15)
//
// Ports
//   refclk           in   board reference clock (also feeds the PLL)
//   rst              in   synchronous active-high reset
//   locked           in   PLL lock, asynchronous to refclk
//   pll_rst          out  PLL reset, high in RESET_PLL and FAIL
//   sys_rst          out  reset for PLL-clocked logic, low only in RUN
//   pll_ok           out  high only in RUN
//   fail             out  high only in FAIL
//   retry_count[3:0] out  failed attempts since rst or last RUN exit
//   lock_loss_count[7:0] out  lock losses seen in RUN (saturating)
//
// Build option
//   PLL_SUP_LOSS_CNT_EN  when defined, lock_loss_count is a real counter;
//                        otherwise it is tied to 0 and no registers exist.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ok,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  // One shared timer; it only ever counts up to (param - 1), so it is sized
  // by the largest of the three cycle parameters.
  localparam int unsigned MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned TW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      retry_q, retry_d;
  logic            sync1_q, lock_s_q;
  logic            attempt_fail;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_RESET_PLL;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;

    case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABILIZE;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STABILIZE: begin
        if (!lock_s_q) begin
          attempt_fail = 1'b1;
        end else if (timer_q == ST_LAST) begin
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
        // A lock loss while running is not a failed attempt: start afresh.
        if (!lock_s_q) begin
          state_d = S_RESET_PLL;
          timer_d = '0;
          retry_d = '0;
        end
      end
      S_FAIL: ;
      default: begin
        state_d = S_RESET_PLL;
        timer_d = '0;
      end
    endcase

    // retry_q never passes RETRY_MAX, so the increment cannot wrap.
    if (attempt_fail) begin
      timer_d = '0;
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAIL;
      end else begin
        state_d = S_RESET_PLL;
        retry_d = retry_q + 1'b1;
      end
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == S_RUN) && !lock_s_q && (loss_q != 8'hFF))
      loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = 8'd0;
`endif

  assign pll_rst     = (state_q == S_RESET_PLL) || (state_q == S_FAIL);
  assign sys_rst     = (state_q != S_RUN);
  assign pll_ok      = (state_q == S_RUN);
  assign fail        = (state_q == S_FAIL);
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
// Edge numbers in comments (E0, F1 ...) count refclk rising edges; E0 is
// the last edge at which rst was sampled high. Outputs are sampled 1 time
// unit after each rising edge.
module tb_pll_lock_supervisor;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, pll_ok, fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;
  logic prev;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(100),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .locked         (locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .pll_ok         (pll_ok),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".pll_rst"}, 8'(pll_rst), 8'd1);
    chk({tag, ".sys_rst"}, 8'(sys_rst), 8'd1);
    chk({tag, ".pll_ok"},  8'(pll_ok),  8'd0);
    chk({tag, ".fail"},    8'(fail),    8'd0);
    chk({tag, ".retry"},   8'(retry_count), 8'd0);
    chk({tag, ".loss"},    lock_loss_count, 8'd0);
  endtask

  initial begin
    // ---- locked tied high from power-on ----
    rst = 1'b1; locked = 1'b1;
    tick(2);                      // E0
    rst = 1'b0;
    chk_rst("por");
    tick(3);                      // E3: last pulse cycle
    chk("lock1.pll_rst_E3", 8'(pll_rst), 8'd1);
    tick(1);                      // E4: WAIT_LOCK
    chk("lock1.pll_rst_E4", 8'(pll_rst), 8'd0);
    chk("lock1.sys_rst_E4", 8'(sys_rst), 8'd1);
    tick(8);                      // E12: still stabilizing
    chk("lock1.sys_rst_E12", 8'(sys_rst), 8'd1);
    chk("lock1.pll_ok_E12",  8'(pll_ok),  8'd0);
    tick(1);                      // E13: RUN
    chk("lock1.sys_rst_E13", 8'(sys_rst), 8'd0);
    chk("lock1.pll_ok_E13",  8'(pll_ok),  8'd1);
    chk("lock1.retry_E13",   8'(retry_count), 8'd0);

    // ---- lock lost in RUN, then relock ----
    locked = 1'b0;
    tick(2);                      // F2
    chk("loss.sys_rst_F2", 8'(sys_rst), 8'd0);
    locked = 1'b1;
    tick(1);                      // F3: back in reset
    chk("loss.sys_rst_F3", 8'(sys_rst), 8'd1);
    chk("loss.pll_rst_F3", 8'(pll_rst), 8'd1);
    chk("loss.pll_ok_F3",  8'(pll_ok),  8'd0);
    chk("loss.retry_F3",   8'(retry_count), 8'd0);
    chk("loss.count_F3",   lock_loss_count, LOSS_EN ? 8'd1 : 8'd0);
    tick(3);                      // F6
    chk("loss.pll_rst_F6", 8'(pll_rst), 8'd1);
    tick(1);                      // F7
    chk("loss.pll_rst_F7", 8'(pll_rst), 8'd0);
    tick(8);                      // F15
    chk("loss.sys_rst_F15", 8'(sys_rst), 8'd1);
    tick(1);                      // F16 = pulse start + 13
    chk("loss.sys_rst_F16", 8'(sys_rst), 8'd0);
    chk("loss.pll_ok_F16",  8'(pll_ok),  8'd1);
    chk("loss.count_F16",   lock_loss_count, LOSS_EN ? 8'd1 : 8'd0);
    locked = 1'b0;                // second loss
    tick(3);
    chk("loss2.sys_rst", 8'(sys_rst), 8'd1);
    chk("loss2.count",   lock_loss_count, LOSS_EN ? 8'd2 : 8'd0);
    chk("loss2.retry",   8'(retry_count), 8'd0);
    locked = 1'b1;

    // ---- one-cycle lock glitch mid-STABILIZE ----
    rst = 1'b1;
    tick(1);                      // E0
    rst = 1'b0;
    chk_rst("rst2");
    tick(7);                      // E7: stabilizing
    chk("glitch.pll_rst_E7", 8'(pll_rst), 8'd0);
    chk("glitch.sys_rst_E7", 8'(sys_rst), 8'd1);
    locked = 1'b0;
    tick(1);                      // E8
    locked = 1'b1;
    tick(1);                      // E9
    chk("glitch.pll_rst_E9", 8'(pll_rst), 8'd0);
    chk("glitch.retry_E9",   8'(retry_count), 8'd0);
    tick(1);                      // E10: attempt failed
    chk("glitch.pll_rst_E10", 8'(pll_rst), 8'd1);
    chk("glitch.retry_E10",   8'(retry_count), 8'd1);
    for (int i = 11; i <= 22; i++) begin
      tick(1);
      chk($sformatf("glitch.sys_rst_E%0d", i), 8'(sys_rst), 8'd1);
      chk($sformatf("glitch.pll_rst_E%0d", i), 8'(pll_rst), (i <= 13) ? 8'd1 : 8'd0);
    end
    tick(1);                      // E23: RUN after the retry
    chk("glitch.pll_ok_E23", 8'(pll_ok), 8'd1);
    chk("glitch.retry_E23",  8'(retry_count), 8'd1);

    // ---- rst in WAIT_LOCK with retry_count=1 ----
    locked = 1'b0;
    rst = 1'b1;
    tick(1);                      // E0
    rst = 1'b0;
    chk_rst("rst3");
    tick(103);                    // E103
    chk("to.retry_E103",   8'(retry_count), 8'd0);
    chk("to.pll_rst_E103", 8'(pll_rst), 8'd0);
    tick(1);                      // E104: first timeout
    chk("to.retry_E104",   8'(retry_count), 8'd1);
    chk("to.pll_rst_E104", 8'(pll_rst), 8'd1);
    tick(46);                     // E150: WAIT_LOCK
    chk("to.pll_rst_E150", 8'(pll_rst), 8'd0);
    chk("to.retry_E150",   8'(retry_count), 8'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_rst("rst_wait");

    // ---- locked tied low: exhaust retries ----
    pulses = 1;
    prev = pll_rst;
    for (int i = 1; i <= 311; i++) begin
      tick(1);
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
    end
    chk("dead.pulses",     8'(pulses), 8'd3);
    chk("dead.fail_E311",  8'(fail), 8'd0);
    chk("dead.retry_E311", 8'(retry_count), 8'd2);
    tick(1);                      // E312
    chk("dead.fail_E312",    8'(fail), 8'd1);
    chk("dead.retry_E312",   8'(retry_count), 8'd2);
    chk("dead.pll_rst_E312", 8'(pll_rst), 8'd1);
    chk("dead.sys_rst_E312", 8'(sys_rst), 8'd1);
    chk("dead.pll_ok_E312",  8'(pll_ok), 8'd0);
    locked = 1'b1;                // FAIL must ignore a late lock
    tick(30);
    chk("dead.fail_hold",    8'(fail), 8'd1);
    chk("dead.pll_rst_hold", 8'(pll_rst), 8'd1);
    chk("dead.sys_rst_hold", 8'(sys_rst), 8'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_rst("rst_fail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
